// File: rtl/speed_pkg.sv
// Shared definitions for the speed scheduler: debounce state encoding,
// default timing parameters and the level-width helper.
package speed_pkg;

  localparam int unsigned DEF_BASE_DIV   = 1000;
  localparam int unsigned DEF_NUM_LEVELS = 4;
  localparam int unsigned DEF_DB_CYCLES  = 50;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_HI = 2'd1,
    PRESSED = 2'd2,
    WAIT_LO = 2'd3
  } db_state_t;

  // Bits needed to index 'levels' speed levels (at least one).
  function automatic int unsigned lvl_width(input int unsigned levels);
    return (levels <= 1) ? 1 : $clog2(levels);
  endfunction

endpackage

// File: rtl/speed_debounce.sv
// Two-flop synchroniser plus debounce FSM for the speed button; emits a
// single-cycle press_evt once a press has been stable for DB_CYCLES samples.
module speed_debounce
  import speed_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DEF_DB_CYCLES,
  parameter int unsigned CNT_W     = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_in,
  output logic press_evt
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

  logic             sync_q;
  logic             s_tog;
  db_state_t        state;
  logic [CNT_W-1:0] db_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q    <= 1'b0;
      s_tog     <= 1'b0;
      state     <= IDLE;
      db_cnt    <= '0;
      press_evt <= 1'b0;
    end else begin
      sync_q    <= raw_in;
      s_tog     <= sync_q;
      press_evt <= 1'b0;
      case (state)
        IDLE: begin
          if (s_tog) begin
            state  <= WAIT_HI;
            db_cnt <= CNT_W'(1);
          end
        end
        WAIT_HI: begin
          if (!s_tog) begin
            state  <= IDLE;
            db_cnt <= '0;
          end else if (db_cnt >= DB_LAST) begin
            // This sample is the DB_CYCLES-th consecutive high one.
            state     <= PRESSED;
            db_cnt    <= '0;
            press_evt <= 1'b1;
          end else begin
            db_cnt <= db_cnt + CNT_W'(1);
          end
        end
        PRESSED: begin
          if (!s_tog) begin
            state  <= WAIT_LO;
            db_cnt <= CNT_W'(1);
          end
        end
        WAIT_LO: begin
          if (s_tog) begin
            state  <= PRESSED;
            db_cnt <= '0;
          end else if (db_cnt >= DB_LAST) begin
            state  <= IDLE;
            db_cnt <= '0;
          end else begin
            db_cnt <= db_cnt + CNT_W'(1);
          end
        end
        default: begin
          state  <= IDLE;
          db_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/speed_sched.sv
// Speed level sequencer: steps through NUM_LEVELS on each debounced press
// and produces a tick enable every (BASE_DIV >> speed_idx) enabled cycles.
module speed_sched
  import speed_pkg::*;
#(
  parameter int unsigned BASE_DIV   = DEF_BASE_DIV,
  parameter int unsigned NUM_LEVELS = DEF_NUM_LEVELS,
  parameter int unsigned DB_CYCLES  = DEF_DB_CYCLES,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned LVL_W      = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             speed_toggle,
  input  logic             enable,
  output logic             tick,
  output logic [LVL_W-1:0] speed_idx,
  output logic [CNT_W-1:0] div_value,
  output logic             level_chg
);

  if (NUM_LEVELS < 1 || (BASE_DIV >> (NUM_LEVELS - 1)) < 2) begin : g_div_chk
    $fatal(1, "speed_sched: BASE_DIV >> (NUM_LEVELS-1) must be at least 2");
  end
  if (LVL_W < lvl_width(NUM_LEVELS)) begin : g_lvl_chk
    $fatal(1, "speed_sched: LVL_W too narrow for NUM_LEVELS");
  end
  if ((64'(BASE_DIV) >> CNT_W) != 0 || (64'(DB_CYCLES) >> CNT_W) != 0) begin : g_cnt_chk
    $fatal(1, "speed_sched: CNT_W too narrow for BASE_DIV or DB_CYCLES");
  end

  localparam logic [LVL_W-1:0] LAST_IDX = LVL_W'(NUM_LEVELS - 1);

  function automatic logic [CNT_W-1:0] div_for(input logic [LVL_W-1:0] idx);
    return CNT_W'(BASE_DIV >> idx);
  endfunction

  logic             press_evt;
  logic             chg_pend;
  logic             at_term;
  logic [CNT_W-1:0] cnt;
  logic [LVL_W-1:0] idx_nxt;

  speed_debounce #(
    .DB_CYCLES (DB_CYCLES),
    .CNT_W     (CNT_W)
  ) u_debounce (
    .clk       (clk),
    .reset     (reset),
    .raw_in    (speed_toggle),
    .press_evt (press_evt)
  );

  always_comb begin
    idx_nxt = (speed_idx == LAST_IDX) ? '0 : speed_idx + LVL_W'(1);
    at_term = (cnt == div_value - CNT_W'(1));
    // A press landing on the terminal count suppresses that tick.
    tick    = enable && at_term && !press_evt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      speed_idx <= '0;
      div_value <= CNT_W'(BASE_DIV);
      chg_pend  <= 1'b0;
      level_chg <= 1'b0;
    end else begin
      chg_pend  <= press_evt;
      level_chg <= chg_pend;
      if (press_evt) begin
        cnt       <= '0;
        speed_idx <= idx_nxt;
        div_value <= div_for(idx_nxt);
      end else if (enable) begin
        cnt <= at_term ? '0 : cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_speed_sched.sv
// Directed bench for speed_sched with BASE_DIV=8, NUM_LEVELS=3, DB_CYCLES=4.
module tb_speed_sched;

  localparam int unsigned BASE_DIV   = 8;
  localparam int unsigned NUM_LEVELS = 3;
  localparam int unsigned DB_CYCLES  = 4;
  localparam int unsigned CNT_W      = 16;
  localparam int unsigned LVL_W      = 2;

  typedef struct packed {
    int h1;
    int l1;
    int h2;
    int l2;
    int exp_chg;
    int exp_idx;
    int exp_div;
  } press_vec_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             speed_toggle;
  logic             enable;
  logic             tick;
  logic [LVL_W-1:0] speed_idx;
  logic [CNT_W-1:0] div_value;
  logic             level_chg;

  int checks = 0;
  int errors = 0;
  int chg_seen = 0;
  press_vec_t vecs [8];

  speed_sched #(
    .BASE_DIV   (BASE_DIV),
    .NUM_LEVELS (NUM_LEVELS),
    .DB_CYCLES  (DB_CYCLES),
    .CNT_W      (CNT_W),
    .LVL_W      (LVL_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .speed_toggle (speed_toggle),
    .enable       (enable),
    .tick         (tick),
    .speed_idx    (speed_idx),
    .div_value    (div_value),
    .level_chg    (level_chg)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion, required finish before timeout");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (level_chg) chg_seen++;
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    speed_toggle = 1'b0;
    enable       = 1'b1;
    repeat (2) step();
    reset    = 1'b0;
    chg_seen = 0;
  endtask

  task automatic hold(input logic val, input int n);
    speed_toggle = val;
    repeat (n) step();
  endtask

  initial begin
    // {high, low, high, low, level_chg pulses, speed_idx, div_value}
    vecs[0] = '{2, 1, 2, 10, 0, 0, 8};   // short bounces
    vecs[1] = '{3, 0, 0, 10, 0, 0, 8};   // one sample short of DB_CYCLES
    vecs[2] = '{4, 0, 0, 10, 1, 1, 4};   // exactly DB_CYCLES
    vecs[3] = '{20, 2, 5, 10, 1, 2, 2};  // bounce on release
    vecs[4] = '{6, 0, 0, 10, 1, 0, 8};   // wrap to level 0
    vecs[5] = '{60, 0, 0, 10, 1, 1, 4};  // long hold, single press
    vecs[6] = '{4, 0, 0, 10, 1, 2, 2};
    vecs[7] = '{5, 1, 5, 10, 1, 0, 8};   // glitch low while pressed

    // Reset values and base tick rate
    do_reset();
    check("reset tick", int'(tick), 0);
    check("reset speed_idx", int'(speed_idx), 0);
    check("reset div_value", int'(div_value), 8);
    check("reset level_chg", int'(level_chg), 0);
    for (int k = 1; k <= 40; k++) begin
      step();
      check($sformatf("base tick k=%0d", k), int'(tick), (k % 8 == 7) ? 1 : 0);
    end
    check("base speed_idx", int'(speed_idx), 0);
    check("base div_value", int'(div_value), 8);

    // Clean press: counter is at 0 here, raw high first sampled at j=1
    speed_toggle = 1'b1;
    for (int j = 1; j <= 34; j++) begin
      step();
      check($sformatf("press idx j=%0d", j), int'(speed_idx), (j >= 7) ? 1 : 0);
      check($sformatf("press div j=%0d", j), int'(div_value), (j >= 7) ? 4 : 8);
      check($sformatf("press chg j=%0d", j), int'(level_chg), (j == 8) ? 1 : 0);
      check($sformatf("press tick j=%0d", j), int'(tick),
            (j >= 7 && (j - 7) % 4 == 3) ? 1 : 0);
      if (j == 20) speed_toggle = 1'b0;
    end

    // Button pattern table
    do_reset();
    for (int i = 0; i < 8; i++) begin
      chg_seen = 0;
      hold(1'b1, vecs[i].h1);
      hold(1'b0, vecs[i].l1);
      hold(1'b1, vecs[i].h2);
      hold(1'b0, vecs[i].l2);
      check($sformatf("vec%0d level_chg count", i), chg_seen, vecs[i].exp_chg);
      check($sformatf("vec%0d speed_idx", i), int'(speed_idx), vecs[i].exp_idx);
      check($sformatf("vec%0d div_value", i), int'(div_value), vecs[i].exp_div);
    end

    // press_evt coincides with cnt==7: tick suppressed, new period from 0
    do_reset();
    for (int j = 1; j <= 12; j++) begin
      step();
      check($sformatf("term tick j=%0d", j), int'(tick), (j == 11) ? 1 : 0);
      check($sformatf("term idx j=%0d", j), int'(speed_idx), (j >= 8) ? 1 : 0);
      if (j == 1) speed_toggle = 1'b1;
    end
    hold(1'b0, 12);

    // enable low holds the count at 3
    do_reset();
    for (int j = 1; j <= 3; j++) begin
      step();
      check($sformatf("en tick j=%0d", j), int'(tick), 0);
    end
    enable = 1'b0;
    for (int j = 4; j <= 13; j++) begin
      step();
      check($sformatf("en hold tick j=%0d", j), int'(tick), 0);
    end
    enable = 1'b1;
    for (int j = 14; j <= 17; j++) begin
      step();
      check($sformatf("en resume tick j=%0d", j), int'(tick), (j == 17) ? 1 : 0);
    end
    enable = 1'b0;
    #1;
    check("en forced low at terminal", int'(tick), 0);
    enable = 1'b1;
    #1;
    check("en restored at terminal", int'(tick), 1);
    step();
    check("en after wrap tick", int'(tick), 0);

    // Reset asserted while the debouncer is in WAIT_HI, mid-count
    do_reset();
    speed_toggle = 1'b1;
    repeat (4) step();
    reset        = 1'b1;
    speed_toggle = 1'b0;
    #1;
    check("async reset tick", int'(tick), 0);
    check("async reset speed_idx", int'(speed_idx), 0);
    check("async reset div_value", int'(div_value), 8);
    check("async reset level_chg", int'(level_chg), 0);
    repeat (3) step();
    reset    = 1'b0;
    chg_seen = 0;
    for (int j = 1; j <= 20; j++) begin
      step();
      check($sformatf("post reset tick j=%0d", j), int'(tick), (j % 8 == 7) ? 1 : 0);
    end
    check("post reset level_chg count", chg_seen, 0);
    check("post reset speed_idx", int'(speed_idx), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
